// File: rtl/codemem_readback.sv
// Purpose: reads code memory word by word and presents each word as two 32-bit halves for host readback.
// Latency: start -> rd_en next cycle -> inst_valid RD_LATENCY+1 cycles after rd_en (3 cycles after start for RD_LATENCY=1).
// Backpressure: a presented word is held until the host has read both halves; strobes outside HOLD are ignored.
module codemem_readback #(
    parameter int CODE_ADDR_WIDTH = 10,
    parameter int CODE_DATA_WIDTH = 64,
    parameter int RD_LATENCY      = 1     // 1..4; the wait counter is 2 bits wide
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       readback_start,
    input  logic                       inst_low_rd_strobe,
    input  logic                       inst_high_rd_strobe,
    output logic [CODE_ADDR_WIDTH-1:0] code_mem_rd_addr,
    output logic                       code_mem_rd_en,
    input  logic [CODE_DATA_WIDTH-1:0] code_mem_rd_data,
    output logic [31:0]                inst_high_value,
    output logic [31:0]                inst_low_value,
    output logic                       inst_valid,
    output logic [CODE_ADDR_WIDTH-1:0] readback_addr,
    output logic                       readback_wrap
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // Counter value in the WAIT cycle during which read data is on the bus.
    localparam logic [1:0] LAST_CNT = 2'(RD_LATENCY - 1);
    localparam logic [CODE_ADDR_WIDTH-1:0] ADDR_MAX = '1;

    logic [1:0]                 state_q, state_d;
    logic [CODE_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                       low_seen_q, low_seen_d;
    logic                       high_seen_q, high_seen_d;
    logic [1:0]                 cnt_q, cnt_d;
    logic [31:0]                high_q, high_d;
    logic [31:0]                low_q, low_d;
    logic                       wrap_q, wrap_d;
    logic                       capture;
    logic                       low_nxt, high_nxt;

    // Next-state logic: a start pulse overrides whatever the FSM is doing.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        low_seen_d  = low_seen_q;
        high_seen_d = high_seen_q;
        cnt_d       = cnt_q;
        wrap_d      = 1'b0;
        capture     = 1'b0;
        low_nxt     = low_seen_q | inst_low_rd_strobe;
        high_nxt    = high_seen_q | inst_high_rd_strobe;

        if (readback_start) begin
            // Abort: any read still in flight is dropped because WAIT is left.
            state_d     = ST_ISSUE;
            addr_d      = '0;
            low_seen_d  = 1'b0;
            high_seen_d = 1'b0;
            cnt_d       = 2'd0;
        end else begin
            case (state_q)
                ST_ISSUE: begin
                    state_d = ST_WAIT;
                    cnt_d   = 2'd0;
                end
                ST_WAIT: begin
                    if (cnt_q == LAST_CNT) begin
                        capture = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                ST_HOLD: begin
                    if (low_nxt && high_nxt) begin
                        state_d     = ST_ISSUE;
                        addr_d      = addr_q + 1'b1;
                        wrap_d      = (addr_q == ADDR_MAX);
                        low_seen_d  = 1'b0;
                        high_seen_d = 1'b0;
                    end else begin
                        low_seen_d  = low_nxt;
                        high_seen_d = high_nxt;
                    end
                end
                default: ;  // IDLE waits for start and ignores strobes
            endcase
        end

        high_d = capture ? code_mem_rd_data[63:32] : high_q;
        low_d  = capture ? code_mem_rd_data[31:0]  : low_q;
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            low_seen_q  <= 1'b0;
            high_seen_q <= 1'b0;
            cnt_q       <= 2'd0;
            high_q      <= 32'd0;
            low_q       <= 32'd0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            low_seen_q  <= low_seen_d;
            high_seen_q <= high_seen_d;
            cnt_q       <= cnt_d;
            high_q      <= high_d;
            low_q       <= low_d;
            wrap_q      <= wrap_d;
        end
    end

    assign code_mem_rd_en   = (state_q == ST_ISSUE);
    assign code_mem_rd_addr = addr_q;
    assign inst_valid       = (state_q == ST_HOLD);
    assign inst_high_value  = high_q;
    assign inst_low_value   = low_q;
    assign readback_addr    = addr_q;
    assign readback_wrap    = wrap_q;

endmodule

// File: tb/tb_codemem_readback.sv
// Purpose: checks two readback instances (10-bit addr/latency 1 and 3-bit addr/latency 3) against a timeline model.
// Latency: model predicts rd_en one cycle after start/exit and inst_valid latency+1 cycles after rd_en.
// Backpressure: bench drives host strobes directly; memory returns data exactly latency cycles after rd_en.
module tb_codemem_readback;

    localparam int AW0 = 10;
    localparam int AW1 = 3;
    localparam int L0  = 1;
    localparam int L1  = 3;
    localparam logic [63:0] GARBAGE = 64'hBAD0_BAD0_BAD0_BAD0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, lo_stb, hi_stb;

    logic [AW0-1:0] rd_addr0, ra0;
    logic [AW1-1:0] rd_addr1, ra1;
    logic           rd_en0, rd_en1, v0, v1, wr0, wr1;
    logic [63:0]    rdd0, rdd1;
    logic [31:0]    hv0, lv0, hv1, lv1;

    codemem_readback #(.CODE_ADDR_WIDTH(AW0), .CODE_DATA_WIDTH(64), .RD_LATENCY(L0)) dut0 (
        .clk(clk), .rst(rst), .readback_start(start),
        .inst_low_rd_strobe(lo_stb), .inst_high_rd_strobe(hi_stb),
        .code_mem_rd_addr(rd_addr0), .code_mem_rd_en(rd_en0), .code_mem_rd_data(rdd0),
        .inst_high_value(hv0), .inst_low_value(lv0), .inst_valid(v0),
        .readback_addr(ra0), .readback_wrap(wr0)
    );

    codemem_readback #(.CODE_ADDR_WIDTH(AW1), .CODE_DATA_WIDTH(64), .RD_LATENCY(L1)) dut1 (
        .clk(clk), .rst(rst), .readback_start(start),
        .inst_low_rd_strobe(lo_stb), .inst_high_rd_strobe(hi_stb),
        .code_mem_rd_addr(rd_addr1), .code_mem_rd_en(rd_en1), .code_mem_rd_data(rdd1),
        .inst_high_value(hv1), .inst_low_value(lv1), .inst_valid(v1),
        .readback_addr(ra1), .readback_wrap(wr1)
    );

    // Per-instance views so one process can handle both
    logic [AW0-1:0] rda [2];
    logic [AW0-1:0] rba [2];
    logic           rde [2];
    logic           vld [2];
    logic           wrp [2];
    logic [31:0]    hvs [2];
    logic [31:0]    lvs [2];
    assign rda[0] = rd_addr0;  assign rda[1] = {{(AW0-AW1){1'b0}}, rd_addr1};
    assign rba[0] = ra0;       assign rba[1] = {{(AW0-AW1){1'b0}}, ra1};
    assign rde[0] = rd_en0;    assign rde[1] = rd_en1;
    assign vld[0] = v0;        assign vld[1] = v1;
    assign wrp[0] = wr0;       assign wrp[1] = wr1;
    assign hvs[0] = hv0;       assign hvs[1] = hv1;
    assign lvs[0] = lv0;       assign lvs[1] = lv1;

    function automatic logic [63:0] word(input int a);
        if (a == 0) return 64'h1111_2222_3333_4444;
        return {32'hA000_0000 | 32'(a), 32'h5000_0000 | 32'(a)};
    endfunction

    function automatic int lat(input int i);
        return (i == 0) ? L0 : L1;
    endfunction

    function automatic int amask(input int i);
        return (i == 0) ? (1 << AW0) - 1 : (1 << AW1) - 1;
    endfunction

    // Memory: fixed-latency pipe, not reset; bus carries garbage when no data is due
    bit [63:0] pd [2][4];
    bit        pv [2][4];
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int s = 3; s > 0; s--) begin
                pd[i][s] <= pd[i][s-1];
                pv[i][s] <= pv[i][s-1];
            end
            pd[i][0] <= word(int'(rda[i]));
            pv[i][0] <= rde[i];
        end
    end
    assign rdd0 = pv[0][L0-1] ? pd[0][L0-1] : GARBAGE;
    assign rdd1 = pv[1][L1-1] ? pd[1][L1-1] : GARBAGE;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit run = 1'b0;

    task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at cycle %0d: got %h, expected %h", nm, inst, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Timeline model: a fetch is a scheduled pair (rd_en cycle, first valid cycle)
    bit          m_act   [2];
    int          m_addr  [2];
    int          m_rden  [2];
    int          m_valid [2];
    int          m_wrap  [2];
    bit          m_lo    [2];
    bit          m_hi    [2];
    logic [31:0] m_hv    [2];
    logic [31:0] m_lv    [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i]  <= 1'b0;
                m_addr[i] <= 0;
                m_rden[i] <= -1;
                m_valid[i] <= -1;
                m_wrap[i] <= -1;
                m_lo[i]   <= 1'b0;
                m_hi[i]   <= 1'b0;
                m_hv[i]   <= 32'd0;
                m_lv[i]   <= 32'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin : per_inst
                int nw, a_addr, a_valid, a_rden, a_wrap;
                bit a_act, a_lo, a_hi, holding;
                logic [63:0] w;
                nw = cyc + 1;
                a_act = m_act[i]; a_addr = m_addr[i]; a_valid = m_valid[i];
                a_rden = m_rden[i]; a_wrap = m_wrap[i]; a_lo = m_lo[i]; a_hi = m_hi[i];
                holding = m_act[i] && (cyc >= m_valid[i]);
                if (start) begin
                    a_act = 1'b1; a_addr = 0; a_rden = nw; a_valid = nw + 1 + lat(i);
                    a_lo = 1'b0; a_hi = 1'b0;
                end else if (holding) begin
                    a_lo = a_lo | lo_stb;
                    a_hi = a_hi | hi_stb;
                    if (a_lo && a_hi) begin
                        a_addr = (a_addr + 1) & amask(i);
                        if (a_addr == 0) a_wrap = nw;
                        a_rden = nw; a_valid = nw + 1 + lat(i);
                        a_lo = 1'b0; a_hi = 1'b0;
                    end
                end
                if (a_act && nw == a_valid) begin
                    w = word(a_addr);
                    m_hv[i] <= w[63:32];
                    m_lv[i] <= w[31:0];
                end
                m_act[i] <= a_act; m_addr[i] <= a_addr; m_rden[i] <= a_rden;
                m_valid[i] <= a_valid; m_wrap[i] <= a_wrap; m_lo[i] <= a_lo; m_hi[i] <= a_hi;
            end
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (run) begin
            for (int i = 0; i < 2; i++) begin
                bit e_rden, e_valid;
                e_rden  = m_act[i] && (cyc == m_rden[i]);
                e_valid = m_act[i] && (cyc >= m_valid[i]);
                chk("rd_en", i, 64'(rde[i]), 64'(e_rden));
                if (e_rden) chk("rd_addr", i, 64'(rda[i]), 64'(m_addr[i]));
                chk("inst_valid", i, 64'(vld[i]), 64'(e_valid));
                chk("readback_addr", i, 64'(rba[i]), 64'(m_addr[i]));
                chk("readback_wrap", i, 64'(wrp[i]), 64'(cyc == m_wrap[i]));
                chk("inst_high", i, 64'(hvs[i]), 64'(m_hv[i]));
                chk("inst_low", i, 64'(lvs[i]), 64'(m_lv[i]));
            end
        end
    end

    int wraps0 = 0;
    int wraps1 = 0;
    always @(negedge clk) begin
        if (wr0) wraps0 <= wraps0 + 1;
        if (wr1) wraps1 <= wraps1 + 1;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic both_strobes();
        lo_stb = 1'b1; hi_stb = 1'b1;
        @(negedge clk);
        lo_stb = 1'b0; hi_stb = 1'b0;
    endtask

    task automatic wait_both();
        int n = 0;
        while (!(v0 && v1) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!(v0 && v1)) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: inst_valid %b/%b after %0d cycles, required 1/1", v0, v1, n);
        end
    endtask

    initial begin
        int w0, w1;
        rst = 1'b1; start = 1'b0; lo_stb = 1'b0; hi_stb = 1'b0;
        @(negedge clk);
        run = 1'b1;
        chk("reset_valid", 0, 64'(v0), 64'd0);
        chk("reset_rd_en", 0, 64'(rd_en0), 64'd0);
        chk("reset_high", 1, 64'(hv1), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Strobes in IDLE do nothing
        both_strobes();
        @(negedge clk);
        chk("idle_addr", 0, 64'(ra0), 64'd0);
        chk("idle_valid", 0, 64'(v0), 64'd0);

        // First fetch: rd_en one cycle after start, valid three cycles after (latency 1)
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("first_rd_en", 0, 64'(rd_en0), 64'd1);
        chk("first_rd_addr", 0, 64'(rd_addr0), 64'd0);
        @(negedge clk);
        chk("first_valid_early", 0, 64'(v0), 64'd0);
        @(negedge clk);
        chk("first_valid", 0, 64'(v0), 64'd1);
        chk("first_high", 0, 64'(hv0), 64'h1111_2222);
        chk("first_low", 0, 64'(lv0), 64'h3333_4444);
        @(negedge clk);
        chk("lat3_valid_early", 1, 64'(v1), 64'd0);
        @(negedge clk);
        chk("lat3_valid", 1, 64'(v1), 64'd1);
        chk("lat3_high", 1, 64'(hv1), 64'h1111_2222);

        // High strobe, then low strobe five cycles later
        hi_stb = 1'b1;
        @(negedge clk);
        hi_stb = 1'b0;
        repeat (4) @(negedge clk);
        chk("half_read_addr", 0, 64'(ra0), 64'd0);
        chk("half_read_valid", 0, 64'(v0), 64'd1);
        lo_stb = 1'b1;
        @(negedge clk);
        lo_stb = 1'b0;
        chk("advance_addr", 0, 64'(ra0), 64'd1);
        chk("advance_valid", 0, 64'(v0), 64'd0);
        chk("advance_rd_en", 0, 64'(rd_en0), 64'd1);
        wait_both();
        chk("word1_high", 0, 64'(hv0), 64'hA000_0001);
        chk("word1_low", 0, 64'(lv0), 64'h5000_0001);

        // Same-cycle strobes advance in one cycle
        both_strobes();
        chk("same_cycle_addr", 0, 64'(ra0), 64'd2);
        wait_both();

        // Strobes during ISSUE/WAIT are neither acted on nor remembered
        both_strobes();
        lo_stb = 1'b1; hi_stb = 1'b1;
        repeat (2) @(negedge clk);
        lo_stb = 1'b0; hi_stb = 1'b0;
        wait_both();
        chk("ignored_strobes_addr", 0, 64'(ra0), 64'd3);
        hi_stb = 1'b1;
        @(negedge clk);
        hi_stb = 1'b0;
        @(negedge clk);
        chk("needs_low_addr", 0, 64'(ra0), 64'd3);
        lo_stb = 1'b1;
        @(negedge clk);
        lo_stb = 1'b0;
        chk("low_completes_addr", 0, 64'(ra0), 64'd4);
        wait_both();

        // Eight consecutive words on the 3-bit instance: exactly one wrap pulse
        w0 = wraps0; w1 = wraps1;
        for (int k = 0; k < 8; k++) begin
            both_strobes();
            wait_both();
        end
        chk("wrap_count", 1, 64'(wraps1 - w1), 64'd1);
        chk("no_wrap_wide", 0, 64'(wraps0 - w0), 64'd0);
        chk("after_wrap_addr", 1, 64'(ra1), 64'd4);
        chk("after_wrap_addr", 0, 64'(ra0), 64'd12);

        // Start during WAIT of address 5 (latency 3): address-5 data never shows
        both_strobes();
        chk("pre_abort_addr", 1, 64'(ra1), 64'd5);
        @(negedge clk);
        pulse_start();
        wait_both();
        chk("abort_addr", 1, 64'(ra1), 64'd0);
        chk("abort_high", 1, 64'(hv1), 64'h1111_2222);
        chk("abort_low", 1, 64'(lv1), 64'h3333_4444);

        // Start coincident with a hold exit: start wins, no wrap
        lo_stb = 1'b1; hi_stb = 1'b1; start = 1'b1;
        @(negedge clk);
        lo_stb = 1'b0; hi_stb = 1'b0; start = 1'b0;
        chk("start_wins_addr", 0, 64'(ra0), 64'd0);
        wait_both();

        // Asynchronous reset in the middle of WAIT
        both_strobes();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rd_en", 1, 64'(rd_en1), 64'd0);
        chk("async_rst_addr", 1, 64'(ra1), 64'd0);
        chk("async_rst_addr", 0, 64'(ra0), 64'd0);
        chk("async_rst_high", 0, 64'(hv0), 64'd0);
        chk("async_rst_low", 1, 64'(lv1), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        lo_stb = 1'b1; hi_stb = 1'b1;
        repeat (3) @(negedge clk);
        lo_stb = 1'b0; hi_stb = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_idle_valid", 0, 64'(v0), 64'd0);
        chk("post_rst_idle_valid", 1, 64'(v1), 64'd0);
        chk("post_rst_idle_addr", 0, 64'(ra0), 64'd0);
        pulse_start();
        wait_both();
        chk("restart_high", 0, 64'(hv0), 64'h1111_2222);
        chk("restart_low", 1, 64'(lv1), 64'h3333_4444);
        repeat (2) @(negedge clk);

        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/codemem_readback.md
CODEMEM_READBACK -- requirements
Module: codemem_readback

Interface
REQ-001 Parameter CODE_ADDR_WIDTH, default 10, code memory word-address width.
REQ-002 Parameter CODE_DATA_WIDTH, default 64, code memory word width; fixed at 64 (two 32-bit halves).
REQ-003 Parameter RD_LATENCY, default 1, code memory read latency in cycles; legal values 1..4.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 readback_start  in  1  one-cycle pulse; (re)starts readback at address 0.
REQ-007 inst_low_rd_strobe  in  1  host read of inst_low_value completed.
REQ-008 inst_high_rd_strobe  in  1  host read of inst_high_value completed.
REQ-009 code_mem_rd_addr  out  CODE_ADDR_WIDTH  code memory read address.
REQ-010 code_mem_rd_en  out  1  code memory read enable.
REQ-011 code_mem_rd_data  in  64  read data, valid exactly RD_LATENCY cycles after the rd_en cycle.
REQ-012 inst_high_value  out  32  bits 63:32 of the presented word.
REQ-013 inst_low_value  out  32  bits 31:0 of the presented word.
REQ-014 inst_valid  out  1  high while inst_*_value hold a fetched word.
REQ-015 readback_addr  out  CODE_ADDR_WIDTH  address of the presented/in-flight word.
REQ-016 readback_wrap  out  1  one-cycle pulse when readback_addr wraps from max to 0.

Function
REQ-017 States IDLE, ISSUE, WAIT, HOLD shall be implemented; state after reset IDLE.
REQ-018 IDLE: all strobes ignored; readback_start -> ISSUE with readback_addr <= 0.
REQ-019 ISSUE (exactly one cycle): code_mem_rd_en=1, code_mem_rd_addr=readback_addr; -> WAIT.
REQ-020 WAIT: counter counts RD_LATENCY-1 cycles; in the cycle code_mem_rd_data is valid, data captured into inst_high_value/inst_low_value, -> HOLD.
REQ-021 code_mem_rd_en shall be 0 in every state except ISSUE.
REQ-022 Latency: start sampled at edge k -> rd_en high cycle k+1 -> inst_valid high from cycle k+2+RD_LATENCY (RD_LATENCY=1: 3 cycles after the start cycle).
REQ-023 HOLD: inst_valid=1; inst_*_value and readback_addr constant; low_seen/high_seen flags set by respective strobes, in either order or same cycle.
REQ-024 HOLD exit: in the cycle where both flags are (or become) set, next state ISSUE, readback_addr+1, flags cleared, inst_valid=0 next cycle.
REQ-025 Repeated strobe of the same half within HOLD shall have no additional effect.
REQ-026 Strobes in ISSUE or WAIT shall be ignored and not remembered.
REQ-027 Address arithmetic modulo 2^CODE_ADDR_WIDTH; increment from all-ones gives 0 and pulses readback_wrap for exactly the cycle readback_addr shows 0 first; readback continues.
REQ-028 readback_start in any non-IDLE state aborts: next state ISSUE, readback_addr 0, flags cleared, inst_valid 0, any in-flight read data discarded (never captured).
REQ-029 readback_start coincident with a HOLD-exit strobe: start wins, address 0, no wrap pulse.
REQ-030 inst_*_value shall change only on capture (REQ-020); they keep the last word when inst_valid falls.

Reset
REQ-031 On rst assertion, immediately (asynchronously): state IDLE, code_mem_rd_en 0, code_mem_rd_addr 0, readback_addr 0, inst_high_value 0, inst_low_value 0, inst_valid 0, readback_wrap 0, flags and WAIT counter 0.
REQ-032 Reset asserted mid-read shall discard the outstanding read; first post-reset fetch only after a new readback_start.
REQ-033 Deassertion shall take effect on the next clk edge; no strobe or start is remembered across reset.

Verification
REQ-034 Memory preloaded addr0=0x1111_2222_3333_4444, RD_LATENCY=1; start pulse -> rd_en cycle+1 addr 0, inst_valid cycle+3, high=0x11112222, low=0x33334444.
REQ-035 In HOLD, high strobe then low strobe 5 cycles later -> address advances to 1 only after the low strobe; same-cycle high+low strobes -> same advance in one cycle.
REQ-036 CODE_ADDR_WIDTH=3, read 8 words consecutively -> 9th fetch at addr 0, readback_wrap high exactly one cycle.
REQ-037 Start issued during WAIT at addr 5 with RD_LATENCY=3 -> addr-5 data never appears; next presented word is addr 0.
REQ-038 rst asserted asynchronously mid-WAIT -> all outputs 0 in the same cycle; no capture follows; strobes ignored until next start.
REQ-039 Strobes in IDLE/ISSUE/WAIT -> no address advance; HOLD still requires both halves afterwards.
